// File: rtl/pic_pkg.sv
// pic_pkg: shared FSM states, command bit positions and OCW2 command codes
package pic_pkg;
  localparam logic [2:0] UNINIT    = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
endpackage

// File: rtl/strobe_edge_detect.sv
// strobe_edge_detect: one-cycle pulse on the first clock a level strobe is seen high
module strobe_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);
  logic prev;
  // history clears on reset so a strobe already high afterwards counts as new
  always_ff @(posedge clk or posedge reset)
    if (reset) prev <= 1'b0;
    else prev <= strobe;
  assign pulse = strobe & ~prev;
endmodule

// File: rtl/command_word_sequencer.sv
// command_word_sequencer: decodes ICW/OCW writes into interrupt controller configuration
module command_word_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] internal_bus,
  input  logic       write_ICW_1,
  input  logic       write_ICW2_4,
  input  logic       write_OCW1,
  input  logic       write_OCW2,
  input  logic       write_OCW3,
  output logic       init_done,
  output logic       ltim,
  output logic       single,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic [4:0] icw4_cfg,
  output logic [7:0] imr,
  output logic       ocw2_strobe,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr,
  output logic       poll_cmd,
  output logic       special_mask
);
  logic [3:0] strb, hit;
  logic [2:0] state, nxt;
  logic       ic4;
  // ICW2..4 and OCW1 are both A1 writes, so they share one detector
  assign strb = {write_OCW3, write_OCW2, write_ICW2_4 | write_OCW1, write_ICW_1};
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_edge
      strobe_edge_detect u_det (.clk(clk), .reset(reset), .strobe(strb[g]), .pulse(hit[g]));
    end
  endgenerate
  // state reached by an A1 write, skipping ICW3/ICW4 when not requested
  always_comb
    nxt = state == WAIT_ICW2 ? (!single ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY) :
          state == WAIT_ICW3 ? (ic4 ? WAIT_ICW4 : READY) :
          state == WAIT_ICW4 ? READY : state;
  // ICW1 restarts initialisation and pre-empts any OCW action in the same cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= UNINIT;
      ic4          <= 1'b0;
      init_done    <= 1'b0;
      ltim         <= 1'b0;
      single       <= 1'b0;
      vector_base  <= '0;
      cascade_cfg  <= '0;
      icw4_cfg     <= '0;
      imr          <= '0;
      ocw2_strobe  <= 1'b0;
      ocw2_cmd     <= '0;
      ocw2_level   <= '0;
      read_isr     <= 1'b0;
      poll_cmd     <= 1'b0;
      special_mask <= 1'b0;
    end else begin
      ocw2_strobe <= 1'b0;
      poll_cmd    <= 1'b0;
      if (hit[0]) begin
        ltim         <= internal_bus[ICW1_LTIM];
        single       <= internal_bus[ICW1_SNGL];
        ic4          <= internal_bus[ICW1_IC4];
        imr          <= '0;
        icw4_cfg     <= '0;
        special_mask <= 1'b0;
        read_isr     <= 1'b0;
        init_done    <= 1'b0;
        state        <= WAIT_ICW2;
      end else begin
        if (hit[1]) begin
          state <= nxt;
          if (state == WAIT_ICW2) vector_base <= internal_bus[7:3];
          if (state == WAIT_ICW3) cascade_cfg <= internal_bus;
          if (state == WAIT_ICW4) icw4_cfg <= internal_bus[4:0];
          if (state == READY) imr <= internal_bus;
          if (state != READY && nxt == READY) init_done <= 1'b1;
        end
        if (hit[2] && state == READY) begin
          ocw2_cmd    <= internal_bus[7:5];
          ocw2_level  <= internal_bus[2:0];
          ocw2_strobe <= 1'b1;
        end
        if (hit[3] && state == READY) begin
          if (internal_bus[OCW3_RR]) read_isr <= internal_bus[OCW3_RIS];
          if (internal_bus[OCW3_ESMM]) special_mask <= internal_bus[OCW3_SMM];
          poll_cmd <= internal_bus[OCW3_P];
        end
      end
    end
endmodule

// File: tb/tb_command_word_sequencer.sv
// tb_command_word_sequencer: scoreboard bench for the command word sequencer
module tb_command_word_sequencer;
  typedef struct packed {
    logic       init_done;
    logic       ltim;
    logic       single;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic [4:0] icw4_cfg;
    logic [7:0] imr;
    logic       ocw2_strobe;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       read_isr;
    logic       poll_cmd;
    logic       special_mask;
  } snap_t;
  typedef struct {
    string tag;
    snap_t v;
  } item_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus = '0;
  logic [4:0] stb = '0;
  logic       init_done, ltim, single, ocw2_strobe, read_isr, poll_cmd, special_mask;
  logic [4:0] vector_base, icw4_cfg;
  logic [7:0] cascade_cfg, imr;
  logic [2:0] ocw2_cmd, ocw2_level;
  snap_t      dut_s, e;
  item_t      sb[$];
  int         total = 0;
  int         bad = 0;
  command_word_sequencer dut (
    .clk(clk), .reset(reset), .internal_bus(bus),
    .write_ICW_1(stb[0]), .write_ICW2_4(stb[1]), .write_OCW1(stb[2]),
    .write_OCW2(stb[3]), .write_OCW3(stb[4]),
    .init_done(init_done), .ltim(ltim), .single(single), .vector_base(vector_base),
    .cascade_cfg(cascade_cfg), .icw4_cfg(icw4_cfg), .imr(imr), .ocw2_strobe(ocw2_strobe),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .read_isr(read_isr),
    .poll_cmd(poll_cmd), .special_mask(special_mask)
  );
  assign dut_s = {init_done, ltim, single, vector_base, cascade_cfg, icw4_cfg, imr,
                  ocw2_strobe, ocw2_cmd, ocw2_level, read_isr, poll_cmd, special_mask};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [38:0] got, input logic [38:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic pop_cmp();
    item_t it;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 39'd1, 39'd0);
      return;
    end
    it = sb.pop_front();
    chk(it.tag, dut_s, it.v);
  endtask
  task automatic check_now(input string tag);
    sb.push_back('{tag, e});
    #1;
    pop_cmp();
  endtask
  task automatic cyc(input string tag);
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    pop_cmp();
  endtask
  task automatic wr(input int ch, input logic [7:0] d, input string tag);
    bus = d;
    stb[ch] = 1'b1;
    cyc(tag);
    stb[ch] = 1'b0;
    e.ocw2_strobe = 1'b0;
    e.poll_cmd = 1'b0;
    cyc({tag, "_idle"});
  endtask
  initial begin
    e = '0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state");
    reset = 1'b0;
    wr(2, 8'hAA, "ocw1_uninit");
    e.single = 1'b1;
    wr(0, 8'h13, "icw1_13");
    e.vector_base = 5'h08;
    wr(1, 8'h40, "icw2_40");
    e.icw4_cfg = 5'h03;
    e.init_done = 1'b1;
    wr(1, 8'h03, "icw4_03");
    e.imr = 8'hF0;
    wr(2, 8'hF0, "ocw1_f0");
    bus = 8'h65;
    stb[3] = 1'b1;
    e.ocw2_strobe = 1'b1;
    e.ocw2_cmd = 3'b011;
    e.ocw2_level = 3'd5;
    cyc("ocw2_65");
    e.ocw2_strobe = 1'b0;
    cyc("ocw2_held");
    stb[3] = 1'b0;
    cyc("ocw2_drop");
    bus = 8'h6F;
    stb[4] = 1'b1;
    e.read_isr = 1'b1;
    e.special_mask = 1'b1;
    e.poll_cmd = 1'b1;
    cyc("ocw3_6f");
    e.poll_cmd = 1'b0;
    cyc("ocw3_held");
    stb[4] = 1'b0;
    cyc("ocw3_drop");
    bus = 8'h10;
    stb = 5'b01001;
    e.imr = '0;
    e.icw4_cfg = '0;
    e.read_isr = 1'b0;
    e.special_mask = 1'b0;
    e.init_done = 1'b0;
    e.single = 1'b0;
    cyc("icw1_wins_ocw2");
    stb = '0;
    cyc("icw1_wins_idle");
    wr(3, 8'h20, "ocw2_preinit");
    bus = 8'h20;
    stb[1] = 1'b1;
    e.vector_base = 5'h04;
    for (int i = 0; i < 4; i++) cyc($sformatf("icw2_held%0d", i));
    stb[1] = 1'b0;
    cyc("icw2_held_drop");
    e.cascade_cfg = 8'h04;
    e.init_done = 1'b1;
    wr(1, 8'h04, "icw3_04");
    e.imr = 8'h0F;
    wr(2, 8'h0F, "ocw1_0f");
    e.read_isr = 1'b1;
    e.special_mask = 1'b1;
    wr(4, 8'h6B, "ocw3_6b");
    wr(4, 8'h08, "ocw3_noop");
    e.read_isr = 1'b0;
    e.special_mask = 1'b0;
    wr(4, 8'h4A, "ocw3_4a");
    e.imr = '0;
    e.init_done = 1'b0;
    wr(0, 8'h10, "icw1_10b");
    wr(1, 8'h20, "icw2_20b");
    reset = 1'b1;
    e = '0;
    check_now("async_reset");
    bus = 8'h13;
    stb[0] = 1'b1;
    cyc("reset_held");
    reset = 1'b0;
    e.single = 1'b1;
    cyc("icw1_high_at_release");
    stb[0] = 1'b0;
    cyc("icw1_release_idle");
    e.vector_base = 5'h08;
    wr(1, 8'h40, "icw2_after_rst");
    e.icw4_cfg = 5'h1D;
    e.init_done = 1'b1;
    wr(1, 8'h1D, "icw4_1d");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
